// File: rtl/param_set_pkg.sv
// Shared types, encodings and digit/gain arithmetic for the front-panel settings block.
package param_set_pkg;

    typedef enum logic [2:0] {IDLE, W_U, W_T, W_H, ED_P, ED_I, ED_D} state_t;

    localparam logic [2:0] FLASH_U = 3'd0;
    localparam logic [2:0] FLASH_T = 3'd1;
    localparam logic [2:0] FLASH_H = 3'd2;

    localparam logic [1:0] PID_NONE = 2'd0;
    localparam logic [1:0] PID_P    = 2'd1;
    localparam logic [1:0] PID_I    = 2'd2;
    localparam logic [1:0] PID_D    = 2'd3;

    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [9:0] GAIN_MAX  = 10'd99;

    function automatic state_t next_on_mode(input state_t s);
        case (s)
            IDLE:    return W_U;
            W_U:     return W_T;
            W_T:     return W_H;
            W_H:     return ED_P;
            ED_P:    return ED_I;
            ED_I:    return ED_D;
            default: return IDLE;
        endcase
    endfunction

    function automatic logic show_of(input state_t s);
        return (s == W_U) || (s == W_T) || (s == W_H);
    endfunction

    function automatic logic [2:0] flash_of(input state_t s);
        case (s)
            W_T:     return FLASH_T;
            W_H:     return FLASH_H;
            default: return FLASH_U;
        endcase
    endfunction

    function automatic logic [1:0] pid_of(input state_t s);
        case (s)
            ED_P:    return PID_P;
            ED_I:    return PID_I;
            ED_D:    return PID_D;
            default: return PID_NONE;
        endcase
    endfunction

    // Digits and gains wrap around their range; no carry reaches neighbouring digits.
    function automatic logic [3:0] digit_step(input logic [3:0] d, input logic up);
        if (up) return (d == DIGIT_MAX) ? 4'd0 : d + 4'd1;
        else    return (d == 4'd0) ? DIGIT_MAX : d - 4'd1;
    endfunction

    function automatic logic [9:0] gain_step(input logic [9:0] g, input logic up);
        if (up) return (g == GAIN_MAX) ? 10'd0 : g + 10'd1;
        else    return (g == 10'd0) ? GAIN_MAX : g - 10'd1;
    endfunction

    function automatic logic [11:0] warn_value(input logic [3:0] h, input logic [3:0] t,
                                               input logic [3:0] u);
        return 12'(h) * 12'd100 + 12'(t) * 12'd10 + 12'(u);
    endfunction

endpackage

// File: rtl/param_set_if.sv
// Front-panel keys in, display-driver settings out; master is the param_set side.
interface param_set_if;
    logic        key_mode_n;
    logic        key_up_n;
    logic        key_down_n;
    logic        show_flag;
    logic [2:0]  flash_flag;
    logic [11:0] data_warn;
    logic [1:0]  pid_show;
    logic [9:0]  p_data;
    logic [9:0]  i_data;
    logic [9:0]  d_data;
    logic        commit;

    modport master (
        input  key_mode_n, key_up_n, key_down_n,
        output show_flag, flash_flag, data_warn, pid_show, p_data, i_data, d_data, commit
    );

    modport slave (
        output key_mode_n, key_up_n, key_down_n,
        input  show_flag, flash_flag, data_warn, pid_show, p_data, i_data, d_data, commit
    );
endinterface

// File: rtl/param_set_key_debounce.sv
// Two-flop synchronizer plus low-level debounce counter producing one press pulse per press.
// The held output exists only when PARAM_SET_AUTOREPEAT_EN is defined.
module key_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk_1ms,
    input  logic rst,
    input  logic key_n,
    output logic press
`ifdef PARAM_SET_AUTOREPEAT_EN
    ,
    output logic held
`endif
);

    localparam int CW = $clog2(DEBOUNCE_MS + 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    // Counter saturates at DEBOUNCE_MS so the pulse fires only on the first qualifying cycle.
    always_ff @(posedge clk_1ms) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2) begin
                cnt <= '0;
            end else if (cnt != CW'(DEBOUNCE_MS)) begin
                cnt   <= cnt + 1'b1;
                press <= (cnt == CW'(DEBOUNCE_MS - 1));
            end
        end
    end

`ifdef PARAM_SET_AUTOREPEAT_EN
    assign held = (cnt == CW'(DEBOUNCE_MS));
`endif

endmodule

// File: rtl/param_set.sv
// Key debounce and menu FSM editing the alarm setpoint and PID gains.
// Optional auto-repeat of up/down keys is enabled by defining PARAM_SET_AUTOREPEAT_EN.
module param_set
    import param_set_pkg::*;
#(
    parameter int DEBOUNCE_MS  = 20,
    parameter int TIMEOUT_MS   = 5000,
    parameter int WARN_DEFAULT = 50,
    parameter int P_DEFAULT    = 10,
    parameter int I_DEFAULT    = 5,
    parameter int D_DEFAULT    = 2
) (
    input logic         clk_1ms,
    input logic         rst,
    param_set_if.master panel
);

    localparam int         TO_W  = $clog2(TIMEOUT_MS);
    localparam logic [3:0] RST_U = 4'(WARN_DEFAULT % 10);
    localparam logic [3:0] RST_T = 4'((WARN_DEFAULT / 10) % 10);
    localparam logic [3:0] RST_H = 4'((WARN_DEFAULT / 100) % 10);

    state_t          state;
    logic [3:0]      dig_u;
    logic [3:0]      dig_t;
    logic [3:0]      dig_h;
    logic [TO_W-1:0] to_cnt;
    logic            mode_evt;
    logic            up_press;
    logic            down_press;
    logic            up_evt;
    logic            down_evt;
    logic            any_evt;

`ifdef PARAM_SET_AUTOREPEAT_EN
    localparam int REPEAT_DELAY  = 600;
    localparam int REPEAT_PERIOD = 100;

    logic       mode_held;
    logic       up_held;
    logic       down_held;
    logic       up_rep;
    logic       down_rep;
    logic [9:0] up_rep_cnt;
    logic [9:0] down_rep_cnt;
`endif

    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_mode (
        .clk_1ms (clk_1ms),
        .rst     (rst),
        .key_n   (panel.key_mode_n),
        .press   (mode_evt)
`ifdef PARAM_SET_AUTOREPEAT_EN
        ,
        .held    (mode_held)
`endif
    );

    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_up (
        .clk_1ms (clk_1ms),
        .rst     (rst),
        .key_n   (panel.key_up_n),
        .press   (up_press)
`ifdef PARAM_SET_AUTOREPEAT_EN
        ,
        .held    (up_held)
`endif
    );

    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_down (
        .clk_1ms (clk_1ms),
        .rst     (rst),
        .key_n   (panel.key_down_n),
        .press   (down_press)
`ifdef PARAM_SET_AUTOREPEAT_EN
        ,
        .held    (down_held)
`endif
    );

`ifdef PARAM_SET_AUTOREPEAT_EN
    // First repeat REPEAT_DELAY cycles after the debounced press, then every REPEAT_PERIOD.
    always_ff @(posedge clk_1ms) begin
        if (rst) begin
            up_rep       <= 1'b0;
            down_rep     <= 1'b0;
            up_rep_cnt   <= '0;
            down_rep_cnt <= '0;
        end else begin
            up_rep   <= 1'b0;
            down_rep <= 1'b0;
            if (!up_held) begin
                up_rep_cnt <= '0;
            end else if (up_rep_cnt == 10'(REPEAT_DELAY - 1)) begin
                up_rep     <= 1'b1;
                up_rep_cnt <= 10'(REPEAT_DELAY - REPEAT_PERIOD);
            end else begin
                up_rep_cnt <= up_rep_cnt + 10'd1;
            end
            if (!down_held) begin
                down_rep_cnt <= '0;
            end else if (down_rep_cnt == 10'(REPEAT_DELAY - 1)) begin
                down_rep     <= 1'b1;
                down_rep_cnt <= 10'(REPEAT_DELAY - REPEAT_PERIOD);
            end else begin
                down_rep_cnt <= down_rep_cnt + 10'd1;
            end
        end
    end

    // A held mode key suppresses repeats, keeping mode ahead of up/down.
    assign up_evt   = up_press   | (up_rep   & ~mode_held);
    assign down_evt = down_press | (down_rep & ~mode_held);
`else
    assign up_evt   = up_press;
    assign down_evt = down_press;
`endif

    assign any_evt = mode_evt | up_evt | down_evt;

    always_ff @(posedge clk_1ms) begin
        if (rst) begin
            state            <= IDLE;
            dig_u            <= RST_U;
            dig_t            <= RST_T;
            dig_h            <= RST_H;
            to_cnt           <= '0;
            panel.show_flag  <= 1'b0;
            panel.flash_flag <= FLASH_U;
            panel.pid_show   <= PID_NONE;
            panel.commit     <= 1'b0;
            panel.data_warn  <= 12'(WARN_DEFAULT);
            panel.p_data     <= 10'(P_DEFAULT);
            panel.i_data     <= 10'(I_DEFAULT);
            panel.d_data     <= 10'(D_DEFAULT);
        end else begin
            panel.commit <= 1'b0;
            if (mode_evt) begin
                to_cnt           <= '0;
                state            <= next_on_mode(state);
                panel.show_flag  <= show_of(next_on_mode(state));
                panel.flash_flag <= flash_of(next_on_mode(state));
                panel.pid_show   <= pid_of(next_on_mode(state));
                panel.commit     <= (state == ED_D);
            end else if (any_evt) begin
                // Up and down together still count as activity but edit nothing.
                to_cnt <= '0;
                if (up_evt != down_evt) begin
                    case (state)
                        W_U: begin
                            dig_u           <= digit_step(dig_u, up_evt);
                            panel.data_warn <= warn_value(dig_h, dig_t, digit_step(dig_u, up_evt));
                        end
                        W_T: begin
                            dig_t           <= digit_step(dig_t, up_evt);
                            panel.data_warn <= warn_value(dig_h, digit_step(dig_t, up_evt), dig_u);
                        end
                        W_H: begin
                            dig_h           <= digit_step(dig_h, up_evt);
                            panel.data_warn <= warn_value(digit_step(dig_h, up_evt), dig_t, dig_u);
                        end
                        ED_P:    panel.p_data <= gain_step(panel.p_data, up_evt);
                        ED_I:    panel.i_data <= gain_step(panel.i_data, up_evt);
                        ED_D:    panel.d_data <= gain_step(panel.d_data, up_evt);
                        default: ;
                    endcase
                end
            end else if (state != IDLE) begin
                if (to_cnt == TO_W'(TIMEOUT_MS - 1)) begin
                    to_cnt           <= '0;
                    state            <= IDLE;
                    panel.show_flag  <= 1'b0;
                    panel.flash_flag <= FLASH_U;
                    panel.pid_show   <= PID_NONE;
                    panel.commit     <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_param_set.sv
// Randomized key-gesture bench for param_set against a cycle-level behavioural model.
// Expectations for the auto-repeat case follow PARAM_SET_AUTOREPEAT_EN.
module tb_param_set;

    localparam int DEB = 20;
    localparam int TMO = 5000;

    logic clk_1ms;
    logic rst;
    int   tests_run;
    int   tests_failed;
    int   commit_seen;

    param_set_if panel();

    param_set #(
        .DEBOUNCE_MS  (DEB),
        .TIMEOUT_MS   (TMO),
        .WARN_DEFAULT (50),
        .P_DEFAULT    (10),
        .I_DEFAULT    (5),
        .D_DEFAULT    (2)
    ) dut (
        .clk_1ms (clk_1ms),
        .rst     (rst),
        .panel   (panel)
    );

    initial clk_1ms = 1'b0;
    always #5 clk_1ms = ~clk_1ms;

    // Model: menu position 0 idle, 1..3 setpoint digits, 4..6 P/I/D gains.
    int  m_state;
    int  m_dig[3];
    int  m_gain[3];
    bit  m_commit;
    bit  m_valid;
    int  m_cyc;
    int  m_last;
    bit  sh1[3];
    bit  sh2[3];
    int  run[3];
    bit  pend[3];
`ifdef PARAM_SET_AUTOREPEAT_EN
    bit  rep_pend[3];
`endif

    function automatic bit raw_key(input int k);
        case (k)
            0:       return panel.key_mode_n;
            1:       return panel.key_up_n;
            default: return panel.key_down_n;
        endcase
    endfunction

    always @(posedge clk_1ms) begin : model
        bit ev_m;
        bit ev_u;
        bit ev_d;
        bit v;
        int delta;
        if (rst) begin
            m_valid  = 1'b1;
            m_state  = 0;
            m_dig[0] = 0;
            m_dig[1] = 5;
            m_dig[2] = 0;
            m_gain[0] = 10;
            m_gain[1] = 5;
            m_gain[2] = 2;
            m_commit = 1'b0;
            m_cyc    = 0;
            m_last   = 0;
            for (int k = 0; k < 3; k++) begin
                sh1[k]  = 1'b1;
                sh2[k]  = 1'b1;
                run[k]  = 0;
                pend[k] = 1'b0;
`ifdef PARAM_SET_AUTOREPEAT_EN
                rep_pend[k] = 1'b0;
`endif
            end
        end else if (m_valid) begin
            m_cyc++;
            ev_m = pend[0];
            ev_u = pend[1];
            ev_d = pend[2];
`ifdef PARAM_SET_AUTOREPEAT_EN
            if (run[0] < DEB) begin
                ev_u = ev_u | rep_pend[1];
                ev_d = ev_d | rep_pend[2];
            end
`endif
            m_commit = 1'b0;
            if (ev_m) begin
                m_last = m_cyc;
                if (m_state == 6) begin
                    m_state  = 0;
                    m_commit = 1'b1;
                end else begin
                    m_state = m_state + 1;
                end
            end else if (ev_u || ev_d) begin
                m_last = m_cyc;
                if (ev_u != ev_d) begin
                    delta = ev_u ? 1 : -1;
                    if (m_state >= 1 && m_state <= 3)
                        m_dig[m_state-1] = (m_dig[m_state-1] + delta + 10) % 10;
                    else if (m_state >= 4)
                        m_gain[m_state-4] = (m_gain[m_state-4] + delta + 100) % 100;
                end
            end else if (m_state != 0 && (m_cyc - m_last) == TMO) begin
                m_state  = 0;
                m_commit = 1'b1;
            end
            for (int k = 0; k < 3; k++) begin
`ifdef PARAM_SET_AUTOREPEAT_EN
                rep_pend[k] = (k != 0) && (run[k] >= DEB + 599) && (((run[k] - DEB - 599) % 100) == 0);
`endif
                v      = sh2[k];
                sh2[k] = sh1[k];
                sh1[k] = raw_key(k);
                run[k] = v ? 0 : run[k] + 1;
                pend[k] = (run[k] == DEB);
            end
        end
    end

    always @(negedge clk_1ms) begin : compare
        logic        e_show;
        logic [2:0]  e_flash;
        logic [1:0]  e_pid;
        logic [11:0] e_warn;
        logic [48:0] e_vec;
        logic [48:0] a_vec;
        if (m_valid) begin
            e_show  = (m_state >= 1 && m_state <= 3);
            e_flash = e_show ? 3'(m_state - 1) : 3'd0;
            e_pid   = (m_state >= 4) ? 2'(m_state - 3) : 2'd0;
            e_warn  = 12'(m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0]);
            e_vec = {e_show, e_flash, e_warn, e_pid, 10'(m_gain[0]), 10'(m_gain[1]),
                     10'(m_gain[2]), m_commit};
            a_vec = {panel.show_flag, panel.flash_flag, panel.data_warn, panel.pid_show,
                     panel.p_data, panel.i_data, panel.d_data, panel.commit};
            tests_run++;
            if (a_vec !== e_vec) begin
                tests_failed++;
                $display("[TB] FAIL cycle_outputs t=%0t got show=%0d flash=%0d warn=%0d pid=%0d p=%0d i=%0d d=%0d commit=%0d expected show=%0d flash=%0d warn=%0d pid=%0d p=%0d i=%0d d=%0d commit=%0d",
                         $time, panel.show_flag, panel.flash_flag, panel.data_warn, panel.pid_show,
                         panel.p_data, panel.i_data, panel.d_data, panel.commit,
                         e_show, e_flash, e_warn, e_pid, m_gain[0], m_gain[1], m_gain[2], m_commit);
            end
            if (panel.commit === 1'b1) commit_seen++;
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_1ms);
    endtask

    // Mask bit 0 mode, bit 1 up, bit 2 down.
    task automatic set_keys(input int mask, input bit level);
        if (mask[0]) panel.key_mode_n = level;
        if (mask[1]) panel.key_up_n   = level;
        if (mask[2]) panel.key_down_n = level;
    endtask

    task automatic apply_stimulus(input int mask, input int bounces, input int hold, input int gap);
        for (int b = 0; b < bounces; b++) begin
            set_keys(mask, 1'b0);
            tick($urandom_range(1, 2));
            set_keys(mask, 1'b1);
            tick($urandom_range(1, 2));
        end
        set_keys(mask, 1'b0);
        tick(hold);
        set_keys(mask, 1'b1);
        tick(gap);
    endtask

    task automatic press(input int mask, input int times);
        for (int n = 0; n < times; n++) apply_stimulus(mask, 0, DEB + 4, 4);
    endtask

    initial begin
        int mask;
        int r;
        tests_run    = 0;
        tests_failed = 0;
        commit_seen  = 0;
        m_valid      = 1'b0;
        rst          = 1'b1;
        panel.key_mode_n = 1'b1;
        panel.key_up_n   = 1'b1;
        panel.key_down_n = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(100);
        check_output("reset_warn", panel.data_warn, 50);
        check_output("reset_p", panel.p_data, 10);
        check_output("reset_i", panel.i_data, 5);
        check_output("reset_d", panel.d_data, 2);
        check_output("reset_show", panel.show_flag, 0);
        check_output("reset_pid", panel.pid_show, 0);
        check_output("reset_no_commit", commit_seen, 0);

        press(1, 1);
        for (int b = 0; b < 5; b++) begin
            set_keys(2, 1'b0);
            tick(1);
            set_keys(2, 1'b1);
            tick(1);
        end
        set_keys(2, 1'b0);
        tick(22);
        check_output("bounce_before_edit", panel.data_warn, 50);
        tick(1);
        check_output("bounce_single_edit", panel.data_warn, 51);
        tick(7);
        set_keys(2, 1'b1);
        tick(4);

        press(2, 8);
        check_output("units_at_nine", panel.data_warn, 59);
        press(2, 1);
        check_output("units_wrap", panel.data_warn, 50);
        press(2, 1);
        press(1, 1);
        press(4, 1);
        check_output("tens_down", panel.data_warn, 41);
        check_output("tens_flash", panel.flash_flag, 1);
        check_output("tens_show", panel.show_flag, 1);

        press(1, 2);
        check_output("edp_pid", panel.pid_show, 1);
        press(4, 11);
        check_output("p_wrap", panel.p_data, 99);
        press(1, 3);
        check_output("exit_commit", commit_seen, 1);
        check_output("exit_pid", panel.pid_show, 0);
        check_output("exit_show", panel.show_flag, 0);

        press(1, 3);
        press(2, 1);
        check_output("hundreds_up", panel.data_warn, 141);
        check_output("hundreds_flash", panel.flash_flag, 2);
        tick(TMO + 10);
        check_output("timeout_show", panel.show_flag, 0);
        check_output("timeout_commit", commit_seen, 2);
        check_output("timeout_retained", panel.data_warn, 141);

        press(1, 2);
        press(2, 1);
        check_output("tens_up", panel.data_warn, 151);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        check_output("midedit_reset_warn", panel.data_warn, 50);
        check_output("midedit_reset_p", panel.p_data, 10);
        check_output("midedit_reset_show", panel.show_flag, 0);
        check_output("midedit_no_commit", commit_seen, 2);

        press(1, 5);
        check_output("edi_pid", panel.pid_show, 2);
        apply_stimulus(2, 0, 1000, 4);
`ifdef PARAM_SET_AUTOREPEAT_EN
        check_output("hold_up_i", panel.i_data, 10);
`else
        check_output("hold_up_i", panel.i_data, 6);
`endif
        press(1, 2);
        check_output("edi_exit_commit", commit_seen, 3);

        for (int g = 0; g < 250; g++) begin
            r = $urandom_range(0, 99);
            if (r < 20)      mask = 1;
            else if (r < 55) mask = 2;
            else if (r < 90) mask = 4;
            else if (r < 95) mask = 6;
            else             mask = 3;
            apply_stimulus(mask, $urandom_range(0, 3), $urandom_range(DEB - 5, DEB + 30),
                           $urandom_range(1, 30));
            r = $urandom_range(0, 99);
            if (r < 2) begin
                tick(TMO + 50);
            end else if (r < 3) begin
                rst = 1'b1;
                tick($urandom_range(1, 3));
                rst = 1'b0;
                tick(2);
            end
        end
        tick(10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
